seven_segment_reader: RTL and testbench
=======================================

# seven_segment_reader

- Receive-side counterpart of the seven-segment display driver: samples the six active-low HEX segment buses, waits for a stable pattern, and decodes each digit back to a 4-bit value with blank/invalid flags.
- Each new stable display state is presented once on a valid/ready handshake.
- Used as a display monitor on the DE-series top level and as a checker in self-test benches.

## Interface

Parameters:
- STABLE_CYCLES, default 4: consecutive matching samples required before a pattern is reported. Legal range 1–65535.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- HEX_IN  in  42  segment buses, active-low. HEX0 = [6:0] … HEX5 = [41:35]. Within a digit, bit 0 = seg a … bit 6 = seg g.
- out_valid  out  1  decoded frame available.
- out_ready  in  1  consumer accepts frame.
- out_digits  out  24  decoded nibbles. Digit n = [4n+3:4n]. 0 where blank or invalid.
- out_blank  out  6  digit n pattern was 7'h7F.
- out_invalid  out  6  digit n pattern not in the decode table and not blank.

## Operation

- Decode table, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Blank = 7F. Any other pattern is invalid.
- Capture register hex_q <= HEX_IN on every edge.
- Stability counter cnt, saturating at STABLE_CYCLES:
  - If HEX_IN != hex_q at an edge: cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
- Register last_rep (42 bits) and flag rep_vld. rep_vld = 0 after reset.
- States:
  - TRACK: on the edge where cnt reaches STABLE_CYCLES and (!rep_vld or hex_q != last_rep):
    - latch the decoded frame into the outputs;
    - last_rep <= hex_q, rep_vld <= 1;
    - go to PRESENT with out_valid = 1.
  - PRESENT: outputs frozen. hex_q and cnt keep tracking the input. On an edge with out_ready = 1: out_valid <= 0, go to TRACK.
- Repeat rule: a stable pattern equal to last_rep is never reported again.
- Glitch rule: a pattern that changes before reaching STABLE_CYCLES is never reported (e.g. A→B→A with B short-lived yields no report for B).
- Input change during PRESENT:
  - does not alter the frozen outputs;
  - is evaluated in TRACK once the handshake completes. If cnt has already saturated, the report fires on the first TRACK edge.

## Timing

- Reset (async): out_valid = 0, out_digits = 0, out_blank = 0, out_invalid = 0, hex_q = 7F (all seven-bit fields), cnt = 0, rep_vld = 0, state TRACK.
- Reset while PRESENT drops out_valid immediately. The frame is lost.
- Latency: with HEX_IN new before edge 0, hex_q captures at edge 0. out_valid is high after edge STABLE_CYCLES if the input is held.
- Handshake:
  - out_valid and the data are held until the edge where out_ready = 1.
  - out_ready is ignored while out_valid = 0.
  - Minimum one TRACK cycle between frames. The next out_valid can assert at the earliest one edge after the accepting edge.
- Counter width: clog2(STABLE_CYCLES+1).

## Configuration

- Macro SEVEN_SEGMENT_READER_ERRCNT_EN.
- Defined: adds output err_count (16 bits, out). It increments by 1 on each reported frame with any out_invalid bit set, saturates at 16'hFFFF, and is reset to 0.
- Undefined: port absent, no counter logic.

## Test plan

- Reset, HEX_IN all 7F held, STABLE_CYCLES=4:
  - out_valid rises after edge 4, out_blank=6'h3F, out_digits=0.
  - Accept with out_ready=1; no further out_valid while the input is held.
- HEX0=40, HEX1=79, rest 7F, out_ready=1:
  - frame out_digits[7:0]=8'h10, out_blank=6'h3C, out_invalid=0.
  - Change HEX0 to 0E: next frame out_digits[3:0]=F.
- HEX2 toggles 24→30 for 2 cycles then back to 24: no frame with digit 3. Exactly one frame for the settled pattern.
- out_ready=0 while the input changes during PRESENT:
  - outputs stay frozen for 20 cycles;
  - after out_ready=1, the new pattern is reported one edge after acceptance.
- HEX3=7'h7E: out_invalid[3]=1, out_digits[15:12]=0. With the macro defined, err_count=1.
- Assert RESET in PRESENT: out_valid=0 asynchronously. After release, the same stable input is reported again (rep_vld cleared).

Source files
------------

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: samples six active-low seven-segment buses, waits for
// a pattern that holds for STABLE_CYCLES consecutive edges, decodes each digit
// back to a nibble with blank/invalid flags, and presents every new stable
// display state once on a valid/ready handshake.
// Optional feature: define SEVEN_SEGMENT_READER_ERRCNT_EN to add err_count,
// a saturating count of reported frames that contain an invalid digit.
module seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic [41:0] HEX_IN,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_digits,
  output logic [5:0]  out_blank,
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  output logic [5:0]  out_invalid,
  output logic [15:0] err_count
`else
  output logic [5:0]  out_invalid
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX = cnt_t'(STABLE_CYCLES);

  typedef enum logic {TRACK, PRESENT} state_t;

  state_t      state_q, state_d;
  logic [41:0] hex_q;
  cnt_t        cnt_q, cnt_d;
  logic [41:0] last_rep_q;
  logic        rep_vld_q;
  logic [23:0] digits_q;
  logic [5:0]  blank_q;
  logic [5:0]  invalid_q;
  logic        load_frame;
  logic        fire;

  logic [23:0] dec_digits;
  logic [5:0]  dec_blank;
  logic [5:0]  dec_invalid;

  // Returns {invalid, blank, nibble} for one active-low digit pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40: decode_seg = {2'b00, 4'h0};
      7'h79: decode_seg = {2'b00, 4'h1};
      7'h24: decode_seg = {2'b00, 4'h2};
      7'h30: decode_seg = {2'b00, 4'h3};
      7'h19: decode_seg = {2'b00, 4'h4};
      7'h12: decode_seg = {2'b00, 4'h5};
      7'h02: decode_seg = {2'b00, 4'h6};
      7'h78: decode_seg = {2'b00, 4'h7};
      7'h00: decode_seg = {2'b00, 4'h8};
      7'h10: decode_seg = {2'b00, 4'h9};
      7'h08: decode_seg = {2'b00, 4'hA};
      7'h03: decode_seg = {2'b00, 4'hB};
      7'h46: decode_seg = {2'b00, 4'hC};
      7'h21: decode_seg = {2'b00, 4'hD};
      7'h06: decode_seg = {2'b00, 4'hE};
      7'h0E: decode_seg = {2'b00, 4'hF};
      7'h7F: decode_seg = {2'b01, 4'h0};
      default: decode_seg = {2'b10, 4'h0};
    endcase
  endfunction

  // Decode all six captured digits in parallel.
  always_comb begin
    logic [5:0] d;
    dec_digits  = '0;
    dec_blank   = '0;
    dec_invalid = '0;
    for (int n = 0; n < 6; n++) begin
      d                  = decode_seg(hex_q[7*n +: 7]);
      dec_digits[4*n +: 4] = d[3:0];
      dec_blank[n]         = d[4];
      dec_invalid[n]       = d[5];
    end
  end

  // Stability counter: restart on any input change, otherwise count up and hold at the limit.
  always_comb begin
    if (HEX_IN != hex_q)       cnt_d = '0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + cnt_t'(1);
  end

  // A report fires when the pattern has just been (or already is) stable long enough and is new.
  assign fire = (cnt_d == CNT_MAX) && (!rep_vld_q || (hex_q != last_rep_q));

  // State register.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) state_q <= TRACK;
    else       state_q <= state_d;
  end

  // Next-state logic and frame-load strobe.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can leave it unassigned and infer a latch.
    state_d    = state_q;
    load_frame = 1'b0;
    case (state_q)
      TRACK: begin
        if (fire) begin
          state_d    = PRESENT;
          load_frame = 1'b1;
        end
      end
      PRESENT: begin
        if (out_ready) state_d = TRACK;
      end
      default: state_d = TRACK;
    endcase
  end

  // Input capture and stability tracking run in both states.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
    if (RESET) begin
      hex_q <= '1;
      cnt_q <= '0;
    end else begin
      hex_q <= HEX_IN;
      cnt_q <= cnt_d;
    end
  end

  // Frame latch plus repeat-suppression memory; outputs stay frozen between loads.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      last_rep_q <= '0;
      rep_vld_q  <= 1'b0;
      digits_q   <= '0;
      blank_q    <= '0;
      invalid_q  <= '0;
    end else if (load_frame) begin
      last_rep_q <= hex_q;
      rep_vld_q  <= 1'b1;
      digits_q   <= dec_digits;
      blank_q    <= dec_blank;
      invalid_q  <= dec_invalid;
    end
  end

  assign out_valid   = (state_q == PRESENT);
  assign out_digits  = digits_q;
  assign out_blank   = blank_q;
  assign out_invalid = invalid_q;

`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  logic [15:0] err_q;

  // Saturating count of reported frames carrying at least one invalid digit.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET)                                        err_q <= '0;
    else if (load_frame && (|dec_invalid) && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader (STABLE_CYCLES = 4): directed
// display patterns, a behavioural model compared every cycle, and literal
// expectations from hand-worked timing.
module tb_seven_segment_reader;

  localparam int S = 4;

  logic        CLOCK_50 = 1'b0;
  logic        RESET    = 1'b1;
  logic [41:0] HEX_IN   = '1;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [23:0] out_digits;
  logic [5:0]  out_blank;
  logic [5:0]  out_invalid;
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
  logic [15:0] err_count;
`endif

  seven_segment_reader #(.STABLE_CYCLES(S)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .HEX_IN     (HEX_IN),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digits (out_digits),
    .out_blank  (out_blank),
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
    .out_invalid(out_invalid),
    .err_count  (err_count)
`else
    .out_invalid(out_invalid)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [41:0] m_prev    = '1;
  int          m_run     = 0;
  bit          m_valid   = 0;
  bit          m_rep_vld = 0;
  logic [41:0] m_last    = '0;
  logic [23:0] m_digits  = '0;
  logic [5:0]  m_blank   = '0;
  logic [5:0]  m_invalid = '0;
  int          m_err     = 0;

  task automatic decode_frame(input logic [41:0] h, output logic [23:0] d,
                              output logic [5:0] b, output logic [5:0] iv);
    logic [6:0] p;
    bit found;
    d = '0; b = '0; iv = '0;
    for (int n = 0; n < 6; n++) begin
      p = h[7*n +: 7];
      found = 0;
      for (int v = 0; v < 16; v++)
        if (SEG[v] == p) begin d[4*n +: 4] = 4'(v); found = 1; end
      if (p == 7'h7F) b[n] = 1'b1;
      else if (!found) iv[n] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge CLOCK_50 or posedge RESET);
    if (RESET) begin
      m_prev = '1; m_run = 0; m_valid = 0; m_rep_vld = 0; m_last = '0;
      m_digits = '0; m_blank = '0; m_invalid = '0; m_err = 0;
    end else begin
      if (HEX_IN == m_prev) begin if (m_run < S) m_run++; end
      else m_run = 0;
      m_prev = HEX_IN;
      if (m_valid) begin
        if (out_ready) m_valid = 0;
      end else if (m_run == S && (!m_rep_vld || HEX_IN != m_last)) begin
        decode_frame(HEX_IN, m_digits, m_blank, m_invalid);
        m_valid = 1; m_last = HEX_IN; m_rep_vld = 1;
        if ((|m_invalid) && m_err < 65535) m_err++;
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  bit cmp_en = 1;
  initial forever begin
    @(negedge CLOCK_50);
    if (cmp_en) begin
      check("cmp_valid",   out_valid,   m_valid);
      check("cmp_digits",  out_digits,  m_digits);
      check("cmp_blank",   out_blank,   m_blank);
      check("cmp_invalid", out_invalid, m_invalid);
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
      check("cmp_err_count", err_count, 64'(m_err));
`endif
    end
  end

  // Frame monitor: counts rising edges of out_valid and watches for a glitch report.
  int frames = 0;
  bit saw3   = 0;
  bit prev_v = 0;
  initial forever begin
    @(negedge CLOCK_50);
    if (out_valid && !prev_v) begin
      frames++;
      if (out_digits[11:8] == 4'h3) saw3 = 1;
    end
    prev_v = out_valid;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [41:0] mk(input logic [6:0] h5, h4, h3, h2, h1, h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic set_hex(input logic [41:0] v);
    @(negedge CLOCK_50);
    #1 HEX_IN = v;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k = 0;
    while (!out_valid && k < budget) begin
      @(negedge CLOCK_50);
      k++;
    end
    check(name, out_valid, 1'b1);
  endtask

  logic [23:0] snap_d;
  logic [5:0]  snap_b, snap_i;
  int          f0;

  initial begin
    // Reset with all digits blank held.
    #22 RESET = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("blank_not_yet_3edges", out_valid, 1'b0);
    @(negedge CLOCK_50);
    check("blank_valid_4edges", out_valid, 1'b1);
    check("blank_mask", out_blank, 6'h3F);
    check("blank_digits", out_digits, 24'h0);
    #1 out_ready = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("blank_no_repeat", frames, 1);

    // HEX0=0, HEX1=1.
    set_hex(mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40));
    wait_valid("p1_timeout", 20);
    check("p1_digits", out_digits[7:0], 8'h10);
    check("p1_blank", out_blank, 6'h3C);
    check("p1_invalid", out_invalid, 6'h00);

    // HEX0 becomes F.
    set_hex(mk(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h0E));
    wait_valid("p2_timeout", 20);
    check("p2_digit0", out_digits[3:0], 4'hF);

    // Glitch: HEX2 settles at 2, blips to 3 for two edges, returns to 2.
    f0 = frames;
    set_hex(mk(7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h79, 7'h0E));
    repeat (20) @(negedge CLOCK_50);
    set_hex(mk(7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h79, 7'h0E));
    @(negedge CLOCK_50);
    set_hex(mk(7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h79, 7'h0E));
    repeat (20) @(negedge CLOCK_50);
    check("glitch_one_frame", frames - f0, 1);
    check("glitch_no_digit3", saw3, 1'b0);

    // Freeze during PRESENT with out_ready low.
    @(negedge CLOCK_50);
    #1 out_ready = 1'b0;
    set_hex(mk(7'h7F, 7'h7F, 7'h19, 7'h24, 7'h79, 7'h0E));
    wait_valid("p4_timeout", 20);
    snap_d = out_digits; snap_b = out_blank; snap_i = out_invalid;
    check("p4_digit3", out_digits[15:12], 4'h4);
    set_hex(mk(7'h7F, 7'h12, 7'h19, 7'h24, 7'h79, 7'h0E));
    repeat (20) @(negedge CLOCK_50);
    check("freeze_valid", out_valid, 1'b1);
    check("freeze_digits", out_digits, snap_d);
    check("freeze_blank", out_blank, snap_b);
    check("freeze_invalid", out_invalid, snap_i);
    #1 out_ready = 1'b1;
    @(negedge CLOCK_50);
    check("accept_drops_valid", out_valid, 1'b0);
    @(negedge CLOCK_50);
    check("pending_reported_next_edge", out_valid, 1'b1);
    check("p5_digit4", out_digits[19:16], 4'h5);

    // Invalid digit on HEX3.
    set_hex(mk(7'h7F, 7'h12, 7'h7E, 7'h24, 7'h79, 7'h0E));
    wait_valid("p6_timeout", 20);
    check("p6_invalid3", out_invalid, 6'h08);
    check("p6_digit3_zero", out_digits[15:12], 4'h0);
    check("p6_blank", out_blank, 6'h20);
`ifdef SEVEN_SEGMENT_READER_ERRCNT_EN
    check("p6_err_count", err_count, 16'd1);
`endif

    // Reset while PRESENT, then the same stable input is reported again.
    @(negedge CLOCK_50);
    #1 out_ready = 1'b0;
    set_hex(mk(7'h06, 7'h12, 7'h7E, 7'h24, 7'h79, 7'h0E));
    wait_valid("p7_timeout", 20);
    check("p7_digit5", out_digits[23:20], 4'hE);
    #1 RESET = 1'b1;
    #1 check("reset_async_valid", out_valid, 1'b0);
    check("reset_async_digits", out_digits, 24'h0);
    @(negedge CLOCK_50);
    #2 RESET = 1'b0;
    wait_valid("rereport_timeout", 20);
    check("rereport_digit5", out_digits[23:20], 4'hE);
    check("rereport_invalid", out_invalid, 6'h08);

    repeat (3) @(negedge CLOCK_50);
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
